// File: rtl/axi_pkg.sv
// Shared AXI definitions for the memory-side read/write slaves.
// Holds burst/response encodings, the default slave-side ID width,
// the only supported beat size and the read-slave FSM state type.
package axi_pkg;

  localparam int ID_WIDTH = 8;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // 4-byte beats: one 32-bit word per beat
  localparam logic [2:0] SIZE_4B = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } rd_state_e;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational AXI burst next-address generator (word-sized beats).
// Ports:
//   addr       current beat byte address
//   len        burst length minus one
//   burst      burst type (FIXED / INCR / WRAP)
//   next_addr  byte address of the following beat
//   wrap_legal len is a legal WRAP length (2, 4, 8 or 16 beats)
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [3:0]            len,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr,
  output logic                  wrap_legal
);

  logic [ADDR_WIDTH-1:0] incr_addr;
  logic [ADDR_WIDTH-1:0] wrap_mask;

  always_comb begin
    incr_addr  = addr + ADDR_WIDTH'(4);
    // for legal lengths (len+1)*4-1 is just {len, 2'b11}
    wrap_mask  = {{(ADDR_WIDTH-6){1'b0}}, len, 2'b11};
    wrap_legal = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
    next_addr  = addr;
    case (burst)
      BURST_INCR: next_addr = incr_addr;
      BURST_WRAP: next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
      default:    next_addr = addr;
    endcase
  end

endmodule

// File: rtl/im_axi_read_slave.sv
// AXI4 read-only slave in front of the instruction SRAM.
// Accepts one AR burst at a time and serves it as a sequence of single-word
// SRAM reads, returning one R beat per word.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   AR*                      read address channel (slave side)
//   R*                       read data channel
//   sram_cs/sram_oe/sram_a   SRAM control and word address
//   sram_do                  SRAM read data, valid one cycle after address
//
// state | meaning
// IDLE  | ready for a new AR request
// FETCH | present word address to SRAM with cs/oe
// WAIT  | SRAM access cycle, capture read data at its end
// RESP  | present R beat until the master takes it
module im_axi_read_slave #(
  parameter int ID_WIDTH   = axi_pkg::ID_WIDTH,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SRAM_AW    = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_WIDTH-1:0]   ARID,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  input  logic [3:0]            ARLEN,
  input  logic [2:0]            ARSIZE,
  input  logic [1:0]            ARBURST,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [ID_WIDTH-1:0]   RID,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic [1:0]            RRESP,
  output logic                  RLAST,
  output logic                  RVALID,
  input  logic                  RREADY,
  output logic                  sram_cs,
  output logic                  sram_oe,
  output logic [SRAM_AW-1:0]    sram_a,
  input  logic [DATA_WIDTH-1:0] sram_do
);

  import axi_pkg::*;

  rd_state_e state_q, state_d;

  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [3:0]            len_q;
  logic [1:0]            burst_q;
  logic                  err_q;
  logic [3:0]            beat_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic [ADDR_WIDTH-1:0] next_addr;
  logic                  wrap_legal;
  logic                  err;
  logic                  last_beat;

  axi_burst_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_gen (
    .addr       (addr_q),
    .len        (len_q),
    .burst      (burst_q),
    .next_addr  (next_addr),
    .wrap_legal (wrap_legal)
  );

  // wrap-length legality is folded in from the latched length so the
  // address generator remains the single owner of that rule
  assign err       = err_q || ((burst_q == BURST_WRAP) && !wrap_legal);
  assign last_beat = (beat_q == len_q);

  always_comb begin
    state_d = state_q;
    ARREADY = 1'b0;
    RVALID  = 1'b0;
    sram_cs = 1'b0;
    sram_oe = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ARREADY = !rst;
        if (ARVALID && !rst) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        sram_cs = !err;
        sram_oe = !err;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        state_d = ST_RESP;
      end
      ST_RESP: begin
        RVALID = 1'b1;
        if (RREADY) state_d = last_beat ? ST_IDLE : ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      burst_q <= '0;
      err_q   <= 1'b0;
      beat_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (ARVALID && ARREADY) begin
        id_q    <= ARID;
        addr_q  <= ARADDR;
        len_q   <= ARLEN;
        burst_q <= ARBURST;
        err_q   <= (ARSIZE != SIZE_4B) || (ARBURST == 2'b11);
        beat_q  <= '0;
      end
      if (state_q == ST_WAIT) rdata_q <= err ? '0 : sram_do;
      if ((state_q == ST_RESP) && RREADY && !last_beat) begin
        beat_q <= beat_q + 4'd1;
        addr_q <= next_addr;
      end
    end
  end

  assign sram_a = addr_q[SRAM_AW+1:2];
  assign RID    = id_q;
  assign RDATA  = rdata_q;
  assign RRESP  = ((state_q == ST_RESP) && err) ? RESP_SLVERR : RESP_OKAY;
  assign RLAST  = (state_q == ST_RESP) && last_beat;

endmodule

// File: tb/tb_im_axi_read_slave.sv
module tb_im_axi_read_slave;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [7:0]  id;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  ARID;
  logic [31:0] ARADDR;
  logic [3:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        ARVALID;
  logic        ARREADY;
  logic [7:0]  RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;
  logic        sram_cs;
  logic        sram_oe;
  logic [13:0] sram_a;
  logic [31:0] sram_do;

  logic [31:0] mem [0:16383];
  beat_t       exp_q[$];
  logic [13:0] sa_q[$];
  int          n_chk = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          exp_rv_cyc = 0;
  int          stall_per_beat = 0;
  int          beats_done = 0;
  bit          cs_seen = 1'b0;

  im_axi_read_slave #(
    .ID_WIDTH   (8),
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .SRAM_AW    (14)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ARID    (ARID),
    .ARADDR  (ARADDR),
    .ARLEN   (ARLEN),
    .ARSIZE  (ARSIZE),
    .ARBURST (ARBURST),
    .ARVALID (ARVALID),
    .ARREADY (ARREADY),
    .RID     (RID),
    .RDATA   (RDATA),
    .RRESP   (RRESP),
    .RLAST   (RLAST),
    .RVALID  (RVALID),
    .RREADY  (RREADY),
    .sram_cs (sram_cs),
    .sram_oe (sram_oe),
    .sram_a  (sram_a),
    .sram_do (sram_do)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: read data appears one cycle after a selected address
  always @(posedge clk) begin
    if (sram_cs && sram_oe) sram_do <= mem[sram_a];
    else                    sram_do <= 32'hDEAD_BEEF;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // reference beat sequence, written as word-index arithmetic
  task automatic push_expect(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                             input logic [2:0] size, input logic [1:0] burst);
    bit          err;
    int unsigned w, n, base;
    beat_t       b;
    err = (size != 3'b010) || (burst == 2'b11) ||
          ((burst == 2'b10) && !((len == 1) || (len == 3) || (len == 7) || (len == 15)));
    w = addr >> 2;
    n = int'(len) + 1;
    for (int i = 0; i < n; i++) begin
      if (!err) sa_q.push_back(14'(w));
      b.data = err ? 32'h0 : mem[14'(w)];
      b.resp = err ? 2'b10 : 2'b00;
      b.last = (i == n - 1);
      b.id   = id;
      exp_q.push_back(b);
      case (burst)
        2'b01:   w = (w + 1) & 32'h3FFF_FFFF;
        2'b10: begin
          base = w - (w % n);
          w = base + ((w - base + 1) % n);
        end
        default: w = w;
      endcase
    end
  endtask

  task automatic send_ar(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int k;
    @(negedge clk);
    ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
    k = 0;
    while (!ARREADY && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!ARREADY) check_val("ar_timeout", 32'(ARREADY), 32'd1);
    else begin
      push_expect(id, addr, len, size, burst);
      exp_rv_cyc = cyc + 3;
    end
    @(posedge clk);
    #1 ARVALID = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    check_val({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    check_val({tag, "_arready_after"}, 32'(ARREADY), 32'd1);
    check_val({tag, "_sram_left"}, 32'(sa_q.size()), 32'd0);
  endtask

  // R-channel / SRAM monitor and RREADY driver
  initial begin : monitor
    bit    prev_rv;
    bit    stalled;
    int    stall_ctr;
    beat_t held, e;
    logic [13:0] ea;
    RREADY = 1'b0;
    prev_rv = 1'b0;
    stalled = 1'b0;
    stall_ctr = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        RREADY = 1'b0;
        prev_rv = 1'b0;
        stalled = 1'b0;
        stall_ctr = 0;
      end else begin
        if (sram_cs) begin
          cs_seen = 1'b1;
          if (sa_q.size() == 0) check_val("sram_cs_unexpected", 32'(sram_cs), 32'd0);
          else begin
            ea = sa_q.pop_front();
            check_val("sram_a", 32'(sram_a), 32'(ea));
            check_val("sram_oe", 32'(sram_oe), 32'd1);
          end
        end
        if (stalled) begin
          check_val("stall_rvalid", 32'(RVALID), 32'd1);
          check_val("stall_rdata", RDATA, held.data);
          check_val("stall_rresp", 32'(RRESP), 32'(held.resp));
          check_val("stall_rlast", 32'(RLAST), 32'(held.last));
          check_val("stall_rid", 32'(RID), 32'(held.id));
        end
        if (RVALID && !prev_rv) check_val("r_latency", 32'(cyc), 32'(exp_rv_cyc));
        if (RVALID) begin
          check_val("arready_busy", 32'(ARREADY), 32'd0);
          if (stall_ctr < stall_per_beat) begin
            RREADY = 1'b0;
            stall_ctr++;
          end else RREADY = 1'b1;
          if (RREADY) begin
            if (exp_q.size() == 0) check_val("r_unexpected", 32'(RVALID), 32'd0);
            else begin
              e = exp_q.pop_front();
              check_val("rdata", RDATA, e.data);
              check_val("rresp", 32'(RRESP), 32'(e.resp));
              check_val("rlast", 32'(RLAST), 32'(e.last));
              check_val("rid", 32'(RID), 32'(e.id));
            end
            beats_done++;
            stall_ctr = 0;
            exp_rv_cyc = cyc + 3;
            stalled = 1'b0;
          end else begin
            stalled = 1'b1;
            held.data = RDATA;
            held.resp = RRESP;
            held.last = RLAST;
            held.id   = RID;
          end
        end else begin
          RREADY = (stall_per_beat == 0);
          stalled = 1'b0;
        end
        prev_rv = RVALID;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int bd0, k;
    rst = 1'b1;
    ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = 3'b010; ARBURST = 2'b01; ARVALID = 1'b0;
    for (int i = 0; i < 16384; i++) mem[i] = 32'hA500_0000 ^ (i * 32'h0001_0203 + 32'h11);

    @(posedge clk);
    @(negedge clk);
    check_val("rst_arready", 32'(ARREADY), 32'd0);
    check_val("rst_rvalid", 32'(RVALID), 32'd0);
    check_val("rst_sram_cs", 32'(sram_cs), 32'd0);
    @(posedge clk);
    #1;
    check_val("rst_rdata", RDATA, 32'd0);
    check_val("rst_rid", 32'(RID), 32'd0);
    check_val("rst_rresp", 32'(RRESP), 32'd0);
    check_val("rst_rlast", 32'(RLAST), 32'd0);
    check_val("rst_sram_a", 32'(sram_a), 32'd0);
    check_val("rst_sram_oe", 32'(sram_oe), 32'd0);
    rst = 1'b0;

    // single beat
    stall_per_beat = 0;
    send_ar(8'h5A, 32'h10, 4'd0, 3'b010, 2'b01);
    wait_done("single");

    // INCR with backpressure
    stall_per_beat = 2;
    send_ar(8'h21, 32'h0, 4'd3, 3'b010, 2'b01);
    wait_done("incr_bp");

    // WRAP len 3 from word 3
    stall_per_beat = 0;
    send_ar(8'h33, 32'h0C, 4'd3, 3'b010, 2'b10);
    wait_done("wrap4");

    // WRAP len 7 from middle, with one stall
    stall_per_beat = 1;
    send_ar(8'h34, 32'h0000_0158, 4'd7, 3'b010, 2'b10);
    wait_done("wrap8");

    // bad size: SLVERR, no SRAM access
    stall_per_beat = 0;
    cs_seen = 1'b0;
    send_ar(8'hE1, 32'h40, 4'd1, 3'b001, 2'b01);
    wait_done("err_size");
    check_val("err_size_cs", 32'(cs_seen), 32'd0);

    // illegal WRAP length and reserved burst type
    cs_seen = 1'b0;
    send_ar(8'hE2, 32'h40, 4'd2, 3'b010, 2'b10);
    wait_done("err_wraplen");
    send_ar(8'hE3, 32'h40, 4'd0, 3'b010, 2'b11);
    wait_done("err_burst");
    check_val("err_other_cs", 32'(cs_seen), 32'd0);

    // FIXED
    send_ar(8'h0F, 32'h20, 4'd2, 3'b010, 2'b00);
    wait_done("fixed");

    // INCR across the top of the SRAM; high bits and low bits ignored
    send_ar(8'h44, 32'hF001_FFFB, 4'd2, 3'b010, 2'b01);
    wait_done("incr_top");

    // reset during the 2nd RESP of a 4-beat burst
    stall_per_beat = 3;
    bd0 = beats_done;
    send_ar(8'h77, 32'h40, 4'd3, 3'b010, 2'b01);
    k = 0;
    while (beats_done != bd0 + 1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    k = 0;
    while (!RVALID && k < 20) begin
      @(negedge clk);
      k++;
    end
    check_val("midrst_second_resp", 32'(RVALID), 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check_val("midrst_rvalid", 32'(RVALID), 32'd0);
    check_val("midrst_arready_in_rst", 32'(ARREADY), 32'd0);
    rst = 1'b0;
    exp_q.delete();
    sa_q.delete();
    #1;
    check_val("midrst_idle", 32'(ARREADY), 32'd1);
    stall_per_beat = 0;
    send_ar(8'h99, 32'h100, 4'd1, 3'b010, 2'b01);
    wait_done("after_rst");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
